// File: rtl/act_read_ctrl_pe_v2.sv
`default_nettype none
// ============================================================================
// Module   : act_read_ctrl_pe_v2
// Purpose  : Activation-read controller for a mid-array PE. Sequences reads
//            from a ping-pong activation BRAM over (act tile, oc tile, accum)
//            loops, streams LANES-wide words to the PE through a 2-entry skid
//            buffer, forwards layer parameters and sync tokens north-to-south
//            and hands consumed buffer halves back to the writer.
// Ports    : clk, rst                      - clock, async active-high reset
//            param_n_* / param_s_*         - layer parameter slice (N -> S)
//            tok_n_* / tok_s_*             - sync token slice (N -> S)
//            buf_full / buf_release        - ping-pong handshake with writer
//            bram_en / bram_addr/bram_dout - BRAM read port (1-cycle latency)
//            pe_act_*                      - activation stream to the PE
// Revision : 1.0 - initial release
// ============================================================================
module act_read_ctrl_pe_v2 #(
    parameter int ACT_WIDTH   = 8,
    parameter int LANES       = 4,
    parameter int READ_DEPTH  = 512,
    parameter int PARAM_WIDTH = 48,
    parameter int AW          = $clog2(READ_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PARAM_WIDTH-1:0]       param_n_data,
    input  logic                         param_n_valid,
    output logic                         param_n_ready,
    output logic [PARAM_WIDTH-1:0]       param_s_data,
    output logic                         param_s_valid,
    input  logic                         param_s_ready,
    input  logic                         tok_n_valid,
    output logic                         tok_n_ready,
    output logic                         tok_s_valid,
    input  logic                         tok_s_ready,
    input  logic [1:0]                   buf_full,
    output logic [1:0]                   buf_release,
    output logic                         bram_en,
    output logic [AW:0]                  bram_addr,
    input  logic [LANES*ACT_WIDTH-1:0]   bram_dout,
    output logic [LANES*ACT_WIDTH-1:0]   pe_act_data,
    output logic                         pe_act_last,
    output logic                         pe_act_valid,
    input  logic                         pe_act_ready
);

    localparam int c_data_w = LANES * ACT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BUF = 3'd1,
        S_READ     = 3'd2,
        S_DRAIN    = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    logic                   r_ping_pong;
    logic [15:0]            r_accum;
    logic [7:0]             r_act_tiles;
    logic [7:0]             r_oc_tiles;
    logic                   r_oc_next;
    logic [15:0]            r_acc;
    logic [7:0]             r_at;
    logic [7:0]             r_ot;
    logic                   r_inflight;
    logic                   r_inflight_last;
    logic [c_data_w:0]      r_skid [2];
    logic                   r_rd_ptr;
    logic                   r_wr_ptr;
    logic [1:0]             r_skid_count;
    logic [PARAM_WIDTH-1:0] r_param_s_data;
    logic                   r_param_s_valid;
    logic                   r_tok_s_valid;

    logic                   w_param_hs;
    logic [15:0]            w_f_accum;
    logic [7:0]             w_f_act;
    logic [7:0]             w_f_oc;
    logic                   w_last_acc;
    logic                   w_last_at;
    logic                   w_last_ot;
    logic                   w_final_read;
    logic                   w_pop;
    logic [2:0]             w_occ;
    logic [AW-1:0]          w_word_addr;

    // ------------------------------------------------------------------
    // Parameter slice. The whole word (including the layer-last flag and
    // any spare bits) travels south untouched; only the loop fields are
    // kept locally.
    // ------------------------------------------------------------------
    assign param_n_ready = (r_state == S_IDLE) && (!r_param_s_valid || param_s_ready);
    assign w_param_hs    = param_n_valid && param_n_ready;
    assign param_s_data  = r_param_s_data;
    assign param_s_valid = r_param_s_valid;

    // Zero-length loop fields behave as a single iteration.
    assign w_f_accum = (param_n_data[15:0]  == 16'd0) ? 16'd1 : param_n_data[15:0];
    assign w_f_act   = (param_n_data[23:16] == 8'd0)  ? 8'd1  : param_n_data[23:16];
    assign w_f_oc    = (param_n_data[31:24] == 8'd0)  ? 8'd1  : param_n_data[31:24];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_param_s_data  <= '0;
            r_param_s_valid <= 1'b0;
        end else if (w_param_hs) begin
            r_param_s_data  <= param_n_data;
            r_param_s_valid <= 1'b1;
        end else if (param_s_ready) begin
            r_param_s_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Token slice, independent of the read sequencer.
    // ------------------------------------------------------------------
    assign tok_n_ready = !r_tok_s_valid || tok_s_ready;
    assign tok_s_valid = r_tok_s_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tok_s_valid <= 1'b0;
        end else if (tok_n_valid && tok_n_ready) begin
            r_tok_s_valid <= 1'b1;
        end else if (tok_s_ready) begin
            r_tok_s_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read issue. Occupancy counts the word leaving the skid buffer this
    // cycle as already gone, so a steady ready=1 stream issues every cycle
    // while skid entries + in-flight words never exceed two.
    // ------------------------------------------------------------------
    assign w_pop   = pe_act_valid && pe_act_ready;
    assign w_occ   = 3'(r_skid_count) + 3'(r_inflight) - 3'(w_pop);
    assign bram_en = (r_state == S_READ) && (w_occ < 3'd2);

    assign w_last_acc   = (r_acc == r_accum - 16'd1);
    assign w_last_at    = (r_at  == r_act_tiles - 8'd1);
    assign w_last_ot    = (r_ot  == r_oc_tiles - 8'd1);
    assign w_final_read = w_last_acc && w_last_at && w_last_ot;

    // Arithmetic is carried out at AW bits, which realises the modulo for a
    // power-of-two half-buffer depth.
    assign w_word_addr = AW'(r_at) * AW'(r_accum) + AW'(r_acc);
    assign bram_addr   = bram_en ? {r_ping_pong, w_word_addr} : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_accum     <= 16'd1;
            r_act_tiles <= 8'd1;
            r_oc_tiles  <= 8'd1;
            r_oc_next   <= 1'b0;
            r_acc       <= '0;
            r_at        <= '0;
            r_ot        <= '0;
        end else if (w_param_hs) begin
            r_accum     <= w_f_accum;
            r_act_tiles <= w_f_act;
            r_oc_tiles  <= w_f_oc;
            r_oc_next   <= param_n_data[32];
            r_acc       <= '0;
            r_at        <= '0;
            r_ot        <= '0;
        end else if (bram_en) begin
            if (w_last_acc) begin
                r_acc <= '0;
                if (r_oc_next) begin
                    // Replay the same act tile across every oc tile.
                    if (w_last_ot) begin
                        r_ot <= '0;
                        r_at <= w_last_at ? 8'd0 : r_at + 8'd1;
                    end else begin
                        r_ot <= r_ot + 8'd1;
                    end
                end else begin
                    // Full act sweep per oc tile.
                    if (w_last_at) begin
                        r_at <= '0;
                        r_ot <= w_last_ot ? 8'd0 : r_ot + 8'd1;
                    end else begin
                        r_at <= r_at + 8'd1;
                    end
                end
            end else begin
                r_acc <= r_acc + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Return path and 2-entry skid buffer. The last tag travels alongside
    // the in-flight read so it lands with its data word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_skid[0]       <= '0;
            r_skid[1]       <= '0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_skid_count    <= 2'd0;
        end else begin
            r_inflight      <= bram_en;
            r_inflight_last <= bram_en && w_last_acc;
            if (r_inflight) begin
                r_skid[r_wr_ptr] <= {r_inflight_last, bram_dout};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_skid_count <= r_skid_count + 2'(r_inflight) - 2'(w_pop);
        end
    end

    assign pe_act_valid = (r_skid_count != 2'd0);
    assign pe_act_data  = r_skid[r_rd_ptr][c_data_w-1:0];
    assign pe_act_last  = r_skid[r_rd_ptr][c_data_w];

    // ------------------------------------------------------------------
    // Sequencer FSM.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ping_pong <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_RELEASE) begin
                r_ping_pong <= ~r_ping_pong;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        buf_release = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (w_param_hs) w_state_nxt = S_WAIT_BUF;
            end
            S_WAIT_BUF: begin
                if (buf_full[r_ping_pong]) w_state_nxt = S_READ;
            end
            S_READ: begin
                if (bram_en && w_final_read) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_inflight) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                buf_release = r_ping_pong ? 2'b10 : 2'b01;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_act_read_ctrl_pe_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_act_read_ctrl_pe_v2
// Purpose  : Scoreboard bench for act_read_ctrl_pe_v2. Expected BRAM
//            addresses and PE words are queued when a layer is launched and
//            compared as the DUT issues reads and delivers words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_act_read_ctrl_pe_v2;

    localparam int c_pw = 48;

    logic            clk = 1'b0;
    logic            rst;
    logic [c_pw-1:0] param_n_data;
    logic            param_n_valid;
    logic            param_n_ready;
    logic [c_pw-1:0] param_s_data;
    logic            param_s_valid;
    logic            param_s_ready;
    logic            tok_n_valid;
    logic            tok_n_ready;
    logic            tok_s_valid;
    logic            tok_s_ready;
    logic [1:0]      buf_full;
    logic [1:0]      buf_release;
    logic            bram_en;
    logic [9:0]      bram_addr;
    logic [31:0]     bram_dout;
    logic [31:0]     pe_act_data;
    logic            pe_act_last;
    logic            pe_act_valid;
    logic            pe_act_ready;

    act_read_ctrl_pe_v2 dut (
        .clk           (clk),
        .rst           (rst),
        .param_n_data  (param_n_data),
        .param_n_valid (param_n_valid),
        .param_n_ready (param_n_ready),
        .param_s_data  (param_s_data),
        .param_s_valid (param_s_valid),
        .param_s_ready (param_s_ready),
        .tok_n_valid   (tok_n_valid),
        .tok_n_ready   (tok_n_ready),
        .tok_s_valid   (tok_s_valid),
        .tok_s_ready   (tok_s_ready),
        .buf_full      (buf_full),
        .buf_release   (buf_release),
        .bram_en       (bram_en),
        .bram_addr     (bram_addr),
        .bram_dout     (bram_dout),
        .pe_act_data   (pe_act_data),
        .pe_act_last   (pe_act_last),
        .pe_act_valid  (pe_act_valid),
        .pe_act_ready  (pe_act_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic       last;
    } exp_t;

    exp_t q_addr[$];
    exp_t q_pe[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_issued = 0;
    int n_popped = 0;
    int rel_total = 0;
    logic [1:0] rel_last = 2'b00;
    int rdy_mode = 0;
    logic        h_pend = 1'b0;
    logic [31:0] h_data;
    logic        h_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bram_word(input logic [9:0] a);
        return {6'b0, a, 6'b0, ~a};
    endfunction

    // BRAM model: one cycle read latency.
    always @(posedge clk) begin
        if (bram_en) bram_dout <= bram_word(bram_addr);
    end

    // PE ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph = 0;
        pe_act_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin pe_act_ready = pat[ph]; ph = (ph + 1) % 4; end
                2: pe_act_ready = 1'($urandom_range(0, 1));
                default: pe_act_ready = 1'b1;
            endcase
        end
    end

    // Monitors sample half a cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bram_en) begin
                n_issued++;
                if (q_addr.size() == 0) begin
                    chk("bram_extra_read", 1, 0);
                end else begin
                    exp_t e;
                    e = q_addr.pop_front();
                    chk("bram_addr", 64'(bram_addr), 64'(e.addr));
                end
            end
            if (h_pend) begin
                chk("hold_valid", 64'(pe_act_valid), 1);
                chk("hold_data", 64'(pe_act_data), 64'(h_data));
                chk("hold_last", 64'(pe_act_last), 64'(h_last));
            end
            if (pe_act_valid && pe_act_ready) begin
                n_popped++;
                if (q_pe.size() == 0) begin
                    chk("pe_extra_word", 1, 0);
                end else begin
                    exp_t e;
                    e = q_pe.pop_front();
                    chk("pe_data", 64'(pe_act_data), 64'(bram_word(e.addr)));
                    chk("pe_last", 64'(pe_act_last), 64'(e.last));
                end
            end
            if (bram_en) chk("outstanding_le2", 64'(n_issued - n_popped <= 2), 1);
            h_pend = pe_act_valid && !pe_act_ready;
            h_data = pe_act_data;
            h_last = pe_act_last;
            if (buf_release != 2'b00) begin
                rel_total++;
                rel_last = buf_release;
            end
        end else begin
            h_pend = 1'b0;
        end
    end

    task automatic push_layer(input int accum, input int act, input int oc,
                              input bit ocn, input bit half);
        int a, t, o;
        a = (accum == 0) ? 1 : accum;
        t = (act == 0) ? 1 : act;
        o = (oc == 0) ? 1 : oc;
        if (ocn) begin
            for (int i = 0; i < t; i++)
                for (int j = 0; j < o; j++)
                    for (int k = 0; k < a; k++) begin
                        exp_t e;
                        e.addr = {half, 9'((i * a + k) % 512)};
                        e.last = (k == a - 1);
                        q_addr.push_back(e);
                        q_pe.push_back(e);
                    end
        end else begin
            for (int j = 0; j < o; j++)
                for (int i = 0; i < t; i++)
                    for (int k = 0; k < a; k++) begin
                        exp_t e;
                        e.addr = {half, 9'((i * a + k) % 512)};
                        e.last = (k == a - 1);
                        q_addr.push_back(e);
                        q_pe.push_back(e);
                    end
        end
    endtask

    task automatic send_param(input int accum, input int act, input int oc, input bit ocn);
        logic [c_pw-1:0] w;
        bit done;
        w = {14'h155, 1'b0, ocn, 8'(oc), 8'(act), 16'(accum)};
        done = 0;
        @(negedge clk);
        param_n_data  = w;
        param_n_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (param_n_ready) begin
                done = 1;
                @(posedge clk);
                #1 param_n_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        chk("param_handshake", 64'(done), 1);
        @(negedge clk);
        chk("param_s_valid_set", 64'(param_s_valid), 1);
        chk("param_s_data", 64'(param_s_data), 64'(w));
    endtask

    task automatic wait_layer(input int exp_rel, input logic [1:0] exp_half);
        bit done;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (rel_total == exp_rel && q_pe.size() == 0 && q_addr.size() == 0) done = 1;
        end
        chk("layer_done", 64'(done), 1);
        chk("release_count", 64'(rel_total), 64'(exp_rel));
        chk("release_half", 64'(rel_last), 64'(exp_half));
    endtask

    initial begin
        int snap;
        logic exp_tok;
        rst           = 1'b1;
        param_n_data  = '0;
        param_n_valid = 1'b0;
        param_s_ready = 1'b1;
        tok_n_valid   = 1'b0;
        tok_s_ready   = 1'b1;
        buf_full      = 2'b00;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_bram_en", 64'(bram_en), 0);
        chk("rst_bram_addr", 64'(bram_addr), 0);
        chk("rst_pe_valid", 64'(pe_act_valid), 0);
        chk("rst_pe_data", 64'(pe_act_data), 0);
        chk("rst_param_s_valid", 64'(param_s_valid), 0);
        chk("rst_tok_s_valid", 64'(tok_s_valid), 0);
        chk("rst_buf_release", 64'(buf_release), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Token slice: one per cycle, one-cycle latency.
        exp_tok = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("tok_s_valid", 64'(tok_s_valid), 64'(exp_tok));
            chk("tok_n_ready", 64'(tok_n_ready), 1);
            tok_n_valid = (k < 4);
            exp_tok = tok_n_valid;
        end
        // Token backpressure holds the slice.
        tok_s_ready = 1'b0;
        tok_n_valid = 1'b1;
        @(negedge clk);
        tok_n_valid = 1'b0;
        chk("tok_hold_valid", 64'(tok_s_valid), 1);
        chk("tok_hold_nready", 64'(tok_n_ready), 0);
        @(negedge clk);
        chk("tok_hold_valid2", 64'(tok_s_valid), 1);
        tok_s_ready = 1'b1;
        @(negedge clk);
        chk("tok_drained", 64'(tok_s_valid), 0);

        // Layer 1: oc_next=1, half 0, always ready.
        buf_full = 2'b01;
        rdy_mode = 0;
        push_layer(3, 2, 2, 1'b1, 1'b0);
        send_param(3, 2, 2, 1'b1);
        wait_layer(1, 2'b01);

        // Layer 2: oc_next=0 on half 1; waits while the half is not full.
        buf_full = 2'b00;
        rdy_mode = 1;
        push_layer(3, 2, 2, 1'b0, 1'b1);
        send_param(3, 2, 2, 1'b0);
        snap = n_issued;
        repeat (20) @(negedge clk);
        chk("wait_buf_no_en", 64'(n_issued - snap), 0);
        buf_full = 2'b10;
        wait_layer(2, 2'b10);

        // Layer 3: oc_next=0 on half 0, random ready, south param stalled.
        buf_full = 2'b01;
        rdy_mode = 2;
        param_s_ready = 1'b0;
        push_layer(3, 2, 2, 1'b0, 1'b0);
        send_param(3, 2, 2, 1'b0);
        chk("param_n_ready_stall", 64'(param_n_ready), 0);
        wait_layer(3, 2'b01);
        chk("param_s_valid_held", 64'(param_s_valid), 1);
        chk("param_n_ready_idle_stall", 64'(param_n_ready), 0);
        param_s_ready = 1'b1;
        @(negedge clk);
        chk("param_s_valid_drain", 64'(param_s_valid), 0);
        chk("param_n_ready_free", 64'(param_n_ready), 1);

        // Layer 4: reset while reading half 1.
        buf_full = 2'b10;
        push_layer(4, 4, 2, 1'b1, 1'b1);
        send_param(4, 4, 2, 1'b1);
        snap = n_issued;
        for (int i = 0; i < 200 && (n_issued - snap) < 3; i++) @(negedge clk);
        chk("reads_before_rst", 64'(n_issued - snap >= 3), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bram_en", 64'(bram_en), 0);
        chk("mid_rst_pe_valid", 64'(pe_act_valid), 0);
        chk("mid_rst_release", 64'(buf_release), 0);
        chk("mid_rst_param_s_valid", 64'(param_s_valid), 0);
        q_addr.delete();
        q_pe.delete();
        n_popped = n_issued;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("no_release_on_rst", 64'(rel_total), 3);

        // Layer 5: zero accum/act fields act as 1; restarts on half 0.
        buf_full = 2'b01;
        push_layer(0, 0, 3, 1'b0, 1'b0);
        send_param(0, 0, 3, 1'b0);
        wait_layer(4, 2'b01);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
